// File: rtl/pifo_reg_ctrl_pkg.sv
// Shared definitions for the pifo_reg controller: FSM state encoding and counter width default.
package pifo_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_t;

  localparam int CNT_WIDTH_DEF = 32;

endpackage

// File: rtl/pifo_reg_ctrl_out_buf.sv
// Two-entry valid/ready FIFO holding {rank,meta} entries popped from the PIFO.
module pifo_reg_ctrl_out_buf #(
  parameter int ENTRY_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         cnt
);

  logic [ENTRY_W-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         cnt_q;
  logic               pop;
  logic               push;

  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = mem[rd_ptr];
  assign cnt      = cnt_q;
  assign pop      = rd_valid && rd_ready;
  // A write into a full buffer is only taken when the head leaves in the same cycle.
  assign push     = wr_en && ((cnt_q != 2'd2) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pifo_reg_ctrl.sv
// Controller for one pifo_reg: enqueue/dequeue strobes, starvation guard, overflow counters
// and flush sequencing, with a 2-deep output buffer toward egress.
module pifo_reg_ctrl
  import pifo_reg_ctrl_pkg::*;
#(
  parameter int L2_REG_WIDTH = 2,
  parameter int RANK_WIDTH   = 8,
  parameter int META_WIDTH   = 8,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [RANK_WIDTH-1:0] enq_rank,
  input  logic [META_WIDTH-1:0] enq_meta,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  pifo_insert,
  output logic [RANK_WIDTH-1:0] pifo_rank_in,
  output logic [META_WIDTH-1:0] pifo_meta_in,
  output logic                  pifo_remove,
  input  logic [RANK_WIDTH-1:0] pifo_rank_out,
  input  logic [META_WIDTH-1:0] pifo_meta_out,
  input  logic                  pifo_valid_out,
  input  logic [RANK_WIDTH-1:0] pifo_max_rank,
  input  logic [L2_REG_WIDTH:0] pifo_num_entries,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  evict_cnt
);

  localparam int ENTRY_W = RANK_WIDTH + META_WIDTH;
  localparam logic [L2_REG_WIDTH:0] FULL_ENTRIES = {1'b1, {L2_REG_WIDTH{1'b0}}};

  ctrl_state_t        state;
  logic               last_ins;
  logic [1:0]         buf_cnt;
  logic               buf_wr;
  logic               guard_block;
  logic               pifo_full;
  logic               overflow;
  logic [ENTRY_W-1:0] buf_rd_data;

  assign pifo_rank_in = enq_rank;
  assign pifo_meta_in = enq_meta;

  // After an insert-only cycle the PIFO min output is briefly invalid; holding off one
  // cycle lets it recover so pending demand is not starved by a stream of inserts.
  assign guard_block = last_ins && (buf_cnt < 2'd2) && (pifo_num_entries != '0);

  always_comb begin
    enq_ready   = 1'b0;
    pifo_remove = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          enq_ready   = !guard_block;
          pifo_remove = pifo_valid_out && (buf_cnt < 2'd2);
        end
        ST_FLUSH: pifo_remove = pifo_valid_out;
        default: ;
      endcase
    end
  end

  assign pifo_insert = enq_valid && enq_ready;
  assign buf_wr      = pifo_remove && (state == ST_RUN);
  assign pifo_full   = (pifo_num_entries == FULL_ENTRIES);
  assign overflow    = pifo_insert && !pifo_remove && pifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      last_ins   <= 1'b0;
      flush_done <= 1'b0;
      drop_cnt   <= '0;
      evict_cnt  <= '0;
    end else begin
      last_ins   <= pifo_insert;
      flush_done <= 1'b0;
      case (state)
        ST_RUN: if (flush) state <= ST_FLUSH;
        ST_FLUSH: begin
          if ((pifo_num_entries == '0) && !pifo_remove) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      if (overflow) begin
        if (enq_rank < pifo_max_rank) evict_cnt <= evict_cnt + CNT_WIDTH'(1);
        else                          drop_cnt  <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  pifo_reg_ctrl_out_buf #(
    .ENTRY_W(ENTRY_W)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data ({pifo_rank_out, pifo_meta_out}),
    .rd_valid(deq_valid),
    .rd_ready(deq_ready),
    .rd_data (buf_rd_data),
    .cnt     (buf_cnt)
  );

  assign {deq_rank, deq_meta} = buf_rd_data;

endmodule

// File: tb/tb_pifo_reg_ctrl.sv
// Bench for pifo_reg_ctrl driving a behavioural priority-queue stand-in for pifo_reg.
module tb_pifo_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid = 1'b0, enq_ready;
  logic [7:0]  enq_rank = '0, enq_meta = '0;
  logic        deq_valid, deq_ready = 1'b0;
  logic [7:0]  deq_rank, deq_meta;
  logic        flush = 1'b0, flush_done;
  logic        pifo_insert, pifo_remove, pifo_valid_out;
  logic [7:0]  pifo_rank_in, pifo_meta_in, pifo_rank_out, pifo_meta_out, pifo_max_rank;
  logic [2:0]  pifo_num_entries;
  logic [31:0] drop_cnt, evict_cnt;

  always #5 clk = ~clk;

  pifo_reg_ctrl #(.L2_REG_WIDTH(2), .RANK_WIDTH(8), .META_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rank(enq_rank), .enq_meta(enq_meta),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_rank(deq_rank), .deq_meta(deq_meta),
    .flush(flush), .flush_done(flush_done),
    .pifo_insert(pifo_insert), .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
    .pifo_remove(pifo_remove), .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
    .pifo_valid_out(pifo_valid_out), .pifo_max_rank(pifo_max_rank),
    .pifo_num_entries(pifo_num_entries), .drop_cnt(drop_cnt), .evict_cnt(evict_cnt)
  );

  // PIFO stand-in: 4-slot list sorted by rank (ties keep arrival order).
  logic [15:0] pq[$];

  function automatic void pq_ins(logic [15:0] e);
    int i = 0;
    while (i < pq.size() && pq[i][15:8] <= e[15:8]) i++;
    pq.insert(i, e);
  endfunction

  always @(posedge clk) begin
    if (rst) pq.delete();
    else begin
      if (pifo_remove && pq.size() != 0) void'(pq.pop_front());
      if (pifo_insert) begin
        if (pq.size() < 4) pq_ins({pifo_rank_in, pifo_meta_in});
        else if (pifo_rank_in < pq[pq.size()-1][15:8]) begin
          void'(pq.pop_back());
          pq_ins({pifo_rank_in, pifo_meta_in});
        end
      end
    end
    pifo_num_entries <= 3'(pq.size());
    pifo_rank_out    <= (pq.size() != 0) ? pq[0][15:8] : 8'h0;
    pifo_meta_out    <= (pq.size() != 0) ? pq[0][7:0]  : 8'h0;
    pifo_max_rank    <= (pq.size() != 0) ? pq[pq.size()-1][15:8] : 8'h0;
    pifo_valid_out   <= !rst && (pq.size() != 0) && !pifo_insert && !pifo_remove;
  end

  // Handshake monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [15:0] acc_q[$], deq_q[$];
  int          acc_cyc[$], deq_cyc[$];
  int          fd_cnt = 0, stab_err = 0, gap_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_head = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && enq_valid && enq_ready) begin
      acc_q.push_back({enq_rank, enq_meta});
      acc_cyc.push_back(cyc);
    end
    if (!rst && enq_valid && !enq_ready) gap_cnt <= gap_cnt + 1;
    if (!rst && deq_valid && deq_ready) begin
      deq_q.push_back({deq_rank, deq_meta});
      deq_cyc.push_back(cyc);
    end
    if (flush_done) fd_cnt <= fd_cnt + 1;
    if (!rst && prev_stall && (!deq_valid || ({deq_rank, deq_meta} !== prev_head)))
      stab_err <= stab_err + 1;
    prev_stall <= !rst && deq_valid && !deq_ready;
    prev_head  <= {deq_rank, deq_meta};
  end

  int checks = 0, passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; enq_valid = 1'b1; enq_rank = 8'hFF; enq_meta = 8'h00; deq_ready = 1'b1; flush = 1'b0;
    tick();
    chk("rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("rst_pifo_insert", 32'(pifo_insert), 32'd0);
    chk("rst_pifo_remove", 32'(pifo_remove), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    chk("rst_evict_cnt", evict_cnt, 32'd0);
    tick();
    rst = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    tick();
  endtask

  task automatic enq(logic [7:0] r, logic [7:0] m);
    bit got = 1'b0;
    enq_valid = 1'b1; enq_rank = r; enq_meta = m;
    for (int i = 0; i < 20 && !got; i++) begin
      got = enq_ready;
      tick();
    end
    enq_valid = 1'b0;
    if (!got) chk("enq_accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic fill_buf(logic [7:0] r1, logic [7:0] r2);
    enq(r1, 8'hB1); repeat (6) tick();
    enq(r2, 8'hB2); repeat (6) tick();
  endtask

  task automatic chk_ranks(string tag, int d0, logic [7:0] exp_r[$]);
    chk({tag, "_count"}, 32'(deq_q.size() - d0), 32'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && d0 + i < deq_q.size(); i++)
      chk($sformatf("%s_rank%0d", tag, i), 32'(deq_q[d0+i][15:8]), 32'(exp_r[i]));
  endtask

  initial begin
    int d0, a0, fd0, st0, g0, miss, max_gap, stop_cyc, n_win;
    bit got;
    logic [7:0] exp_r[$], tail[$];
    logic [15:0] outst[$];
    logic [7:0] seq;

    // Scenario 1: single entry latency.
    do_reset();
    chk("run_enq_ready", 32'(enq_ready), 32'd1);
    deq_ready = 1'b1;
    d0 = deq_q.size(); a0 = acc_q.size();
    enq(8'd5, 8'hA1);
    repeat (8) tick();
    chk("s1_deq_count", 32'(deq_q.size() - d0), 32'd1);
    if (deq_q.size() > d0) begin
      chk("s1_rank", 32'(deq_q[d0][15:8]), 32'd5);
      chk("s1_meta", 32'(deq_q[d0][7:0]), 32'hA1);
      chk("s1_latency", 32'(deq_cyc[d0] - acc_cyc[a0]), 32'd3);
    end

    // Scenario 2: ordering while stalled, behind two already-buffered entries.
    do_reset();
    st0 = stab_err; d0 = deq_q.size();
    fill_buf(8'd50, 8'd60);
    tail = '{8'd9, 8'd3, 8'd7, 8'd1};
    foreach (tail[i]) enq(tail[i], 8'(i));
    repeat (4) tick();
    chk("s2_pifo_occupancy", 32'(pifo_num_entries), 32'd4);
    chk("s2_stall_head", 32'({deq_valid, deq_rank}), 32'h132);
    chk("s2_no_deq_while_stalled", 32'(deq_q.size() - d0), 32'd0);
    deq_ready = 1'b1;
    repeat (20) tick();
    tail.sort();
    exp_r = '{8'd50, 8'd60};
    foreach (tail[i]) exp_r.push_back(tail[i]);
    chk_ranks("s2", d0, exp_r);
    chk("s2_stable_stall", 32'(stab_err - st0), 32'd0);

    // Scenario 3: continuous enqueue with demand must not starve dequeues.
    do_reset();
    deq_ready = 1'b1;
    d0 = deq_q.size(); a0 = acc_q.size(); g0 = gap_cnt;
    enq_valid = 1'b1; enq_rank = 8'd10; enq_meta = 8'd0;
    for (int i = 0; i < 40; i++) begin
      got = enq_ready;
      tick();
      if (got) begin enq_rank += 8'd10; enq_meta += 8'd1; end
    end
    enq_valid = 1'b0;
    stop_cyc = cyc;
    repeat (10) tick();
    max_gap = 0; n_win = 0;
    for (int i = d0 + 1; i < deq_q.size(); i++)
      if (deq_cyc[i] < stop_cyc) begin
        n_win++;
        if (deq_cyc[i] - deq_cyc[i-1] > max_gap) max_gap = deq_cyc[i] - deq_cyc[i-1];
      end
    chk("s3_max_gap_le3", 32'(max_gap <= 3), 32'd1);
    chk("s3_deq_progress", 32'(n_win >= 10), 32'd1);
    chk("s3_enq_ready_gaps", 32'(gap_cnt > g0), 32'd1);
    exp_r.delete();
    for (int i = a0; i < acc_q.size(); i++) exp_r.push_back(acc_q[i][15:8]);
    chk_ranks("s3", d0, exp_r);
    chk("s3_no_drop", drop_cnt, 32'd0);
    chk("s3_no_evict", evict_cnt, 32'd0);

    // Scenario 4: overflow eviction and drop.
    do_reset();
    d0 = deq_q.size();
    fill_buf(8'd50, 8'd60);
    enq(8'd4, 8'h04); enq(8'd6, 8'h06); enq(8'd8, 8'h08); enq(8'd10, 8'h0A);
    tick();
    chk("s4_full", 32'(pifo_num_entries), 32'd4);
    enq(8'd5, 8'h05); tick();
    chk("s4_evict_cnt", evict_cnt, 32'd1);
    chk("s4_drop_cnt_before", drop_cnt, 32'd0);
    enq(8'd12, 8'h0C); tick();
    chk("s4_drop_cnt", drop_cnt, 32'd1);
    chk("s4_evict_cnt_after", evict_cnt, 32'd1);
    deq_ready = 1'b1;
    repeat (20) tick();
    exp_r = '{8'd50, 8'd60, 8'd4, 8'd5, 8'd6, 8'd8};
    chk_ranks("s4", d0, exp_r);

    // Scenario 5: flush discards PIFO contents, buffer keeps draining.
    do_reset();
    d0 = deq_q.size(); fd0 = fd_cnt;
    fill_buf(8'd50, 8'd60);
    enq(8'd4, 8'h04); enq(8'd6, 8'h06); enq(8'd8, 8'h08); enq(8'd10, 8'h0A);
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("s5_enq_ready_flush", 32'(enq_ready), 32'd0);
    deq_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (flush_done) got = 1'b1;
      else tick();
    end
    chk("s5_flush_done_seen", 32'(got), 32'd1);
    chk("s5_pifo_empty", 32'(pifo_num_entries), 32'd0);
    tick();
    chk("s5_enq_ready_after", 32'(enq_ready), 32'd1);
    repeat (5) tick();
    chk("s5_flush_done_once", 32'(fd_cnt - fd0), 32'd1);
    exp_r = '{8'd50, 8'd60};
    chk_ranks("s5", d0, exp_r);

    // Scenario 6: reset in the middle of a flush.
    do_reset();
    fill_buf(8'd50, 8'd60);
    enq(8'd4, 8'h04); enq(8'd6, 8'h06); enq(8'd8, 8'h08); enq(8'd10, 8'h0A);
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0; tick();
    fd0 = fd_cnt;
    rst = 1'b1; tick();
    chk("s6_rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("s6_rst_remove", 32'(pifo_remove), 32'd0);
    chk("s6_rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("s6_rst_flush_done", 32'(flush_done), 32'd0);
    rst = 1'b0; tick();
    chk("s6_run_enq_ready", 32'(enq_ready), 32'd1);
    repeat (10) tick();
    chk("s6_no_flush_done", 32'(fd_cnt - fd0), 32'd0);
    deq_ready = 1'b1;
    d0 = deq_q.size(); a0 = acc_q.size();
    enq(8'd2, 8'h33);
    repeat (8) tick();
    chk("s6_deq_count", 32'(deq_q.size() - d0), 32'd1);
    if (deq_q.size() > d0) begin
      chk("s6_rank", 32'(deq_q[d0][15:8]), 32'd2);
      chk("s6_latency", 32'(deq_cyc[d0] - acc_cyc[a0]), 32'd3);
    end

    // Random traffic: every accepted entry leaves once or is accounted as a loss.
    do_reset();
    d0 = deq_q.size(); a0 = acc_q.size(); st0 = stab_err;
    seq = 8'd0;
    for (int i = 0; i < 240; i++) begin
      enq_valid = ($urandom_range(0, 1) == 1);
      enq_rank  = 8'($urandom_range(0, 255));
      enq_meta  = seq;
      deq_ready = ($urandom_range(0, 3) != 0);
      got = enq_valid && enq_ready;
      tick();
      if (got) seq += 8'd1;
    end
    enq_valid = 1'b0; deq_ready = 1'b1;
    repeat (30) tick();
    outst.delete();
    for (int i = a0; i < acc_q.size(); i++) outst.push_back(acc_q[i]);
    miss = 0;
    for (int i = d0; i < deq_q.size(); i++) begin
      int idx = -1;
      foreach (outst[j]) if (idx < 0 && outst[j] === deq_q[i]) idx = j;
      if (idx < 0) miss++;
      else outst.delete(idx);
    end
    chk("rnd_unknown_deq", 32'(miss), 32'd0);
    chk("rnd_losses_match_counters", 32'(outst.size()), drop_cnt + evict_cnt);
    chk("rnd_stable_stall", 32'(stab_err - st0), 32'd0);
    chk("rnd_buffer_empty", 32'(deq_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
